// File: rtl/sram_resp_pkg.sv
// Shared widths, FSM state type and lane helper for the SRAM responder.
package sram_resp_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int LAT_W   = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } state_t;

    // Active-low UB_N/LB_N -> active-high {upper, lower} lane enables.
    function automatic logic [1:0] lane_en(input logic ub_n, input logic lb_n);
        return {~ub_n, ~lb_n};
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// SRAM pin bundle: the master owns address/strobes, DQ is a shared tristate bus.
interface sram_responder_if;
    import sram_resp_pkg::*;

    logic [SRAM_AW-1:0] SRAM_ADDR;
    wire  [SRAM_DW-1:0] SRAM_DQ;
    logic               SRAM_CE_N;
    logic               SRAM_OE_N;
    logic               SRAM_WE_N;
    logic               SRAM_UB_N;
    logic               SRAM_LB_N;

    modport master (
        output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        inout  SRAM_DQ
    );

    modport slave (
        input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        inout  SRAM_DQ
    );
endinterface

// File: rtl/sram_resp_mem.sv
// 2^AW x 16 word array with per-byte-lane write enables.
// Latency: write commits on the edge; read data is registered one edge after i_raddr.
// No backpressure: accepts a write and a read every cycle.
module sram_resp_mem
    import sram_resp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [1:0]         i_be,
    input  logic [AW-1:0]      i_waddr,
    input  logic [SRAM_DW-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [SRAM_DW-1:0] o_rdata
);

    logic [SRAM_DW-1:0] r_mem [2**AW];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (i_we && i_be[1]) begin
            r_mem[i_waddr][15:8] <= i_wdata[15:8];
        end
        if (i_we && i_be[0]) begin
            r_mem[i_waddr][7:0] <= i_wdata[7:0];
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM device responder: one-cycle writes, reads drive DQ READ_LAT edges after the start edge.
// Latency: write commits on its sampling edge; read data valid READ_LAT posedges later.
// No backpressure: the master owns timing; optional checker under SRAM_RESP_CHECK_EN.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_responder_if.slave     bus,
    output logic [15:0]         wr_count,
    output logic [15:0]         rd_count,
    output logic                proto_err
);

    logic [MEM_AW-1:0]  w_addr;
    logic [1:0]         w_lane;
    logic               w_sel;
    logic               w_rd_req;
    logic               w_wr_req;
    logic               w_load;
    logic               w_enter;
    logic               w_drv_hi;
    logic               w_drv_lo;
    logic               w_unused;
    logic [SRAM_DW-1:0] w_rdata;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_cnt;
    logic [LAT_W-1:0]   w_cnt_nxt;
    logic [MEM_AW-1:0]  r_addr;
    logic [MEM_AW-1:0]  w_addr_nxt;
    logic               r_dvld;

    assign w_addr   = bus.SRAM_ADDR[MEM_AW-1:0];
    assign w_lane   = lane_en(bus.SRAM_UB_N, bus.SRAM_LB_N);
    assign w_sel    = ~bus.SRAM_CE_N;
    assign w_rd_req = w_sel & ~bus.SRAM_OE_N & bus.SRAM_WE_N;
    assign w_wr_req = w_sel & ~bus.SRAM_WE_N;
    assign w_unused = ^bus.SRAM_ADDR[SRAM_AW-1:MEM_AW];

    // Any loss of the read strobes (CE/OE high or WE low) drops the access back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = w_rd_req;
            end
            RD_WAIT, RD_DRIVE: begin
                if (!w_rd_req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_addr != r_addr) begin
                    w_load = 1'b1;
                end else if (r_state == RD_WAIT) begin
                    w_cnt_nxt = r_cnt - LAT_W'(1);
                    if (r_cnt == LAT_W'(1)) begin
                        w_state_nxt = RD_DRIVE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_load) begin
            w_addr_nxt  = w_addr;
            w_cnt_nxt   = LAT_W'(READ_LAT - 1);
            w_state_nxt = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;
        end
    end

    assign w_enter = (w_state_nxt == RD_DRIVE) && ((r_state != RD_DRIVE) || w_load);

    // RD_DRIVE is entered one edge early so the registered array read lands on edge READ_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_dvld   <= 1'b0;
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_dvld  <= (r_state == RD_DRIVE) && (w_state_nxt == RD_DRIVE) && !w_load;
            if (w_wr_req && (|w_lane)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (w_enter) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end

    sram_resp_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_req & ~rst),
        .i_be    (w_lane),
        .i_waddr (w_addr),
        .i_wdata (bus.SRAM_DQ),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    assign w_drv_hi = r_dvld & w_rd_req & w_lane[1];
    assign w_drv_lo = r_dvld & w_rd_req & w_lane[0];

    assign bus.SRAM_DQ[15:8] = w_drv_hi ? w_rdata[15:8] : 8'hzz;
    assign bus.SRAM_DQ[7:0]  = w_drv_lo ? w_rdata[7:0]  : 8'hzz;

`ifdef SRAM_RESP_CHECK_EN
    logic r_proto_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_sel & ((~bus.SRAM_WE_N & ~bus.SRAM_OE_N) | (w_lane == 2'b00));
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
- REQ-001: Parameter MEM_AW, default 10, is the internal word-address width; depth is 2^MEM_AW 16-bit words.
- REQ-002: Parameter READ_LAT, default 2, legal 1..7, is the number of clk edges from read sample to DQ valid.
- REQ-003: clk  input  1  sole clock; all state updates on posedge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: SRAM_ADDR  input  18  word address; only bits [MEM_AW-1:0] are decoded.
- REQ-006: SRAM_DQ  inout  16  data bus; driven only per REQ-015, otherwise high-Z.
- REQ-007: SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  input  1 each  active-low chip enable, output enable and write enable.
- REQ-008: SRAM_UB_N, SRAM_LB_N  input  1 each  active-low upper-lane [15:8] and lower-lane [7:0] enables.
- REQ-009: wr_count  output  16  committed writes, wraps at 16'hFFFF.
- REQ-010: rd_count  output  16  completed reads, wraps at 16'hFFFF.
- REQ-011: proto_err  output  1  one-cycle protocol-violation pulse (only with SRAM_RESP_CHECK_EN).

Function
- REQ-012: States: IDLE, RD_WAIT, RD_DRIVE; writes complete in one cycle and do not leave IDLE.
- REQ-013: Write: at a posedge sampling CE_N=0 and WE_N=0, each enabled lane of mem[ADDR] takes DQ; disabled lanes keep their value; wr_count increments if at least one lane is enabled.
- REQ-014: Read start: from IDLE, sampling CE_N=0, OE_N=0 and WE_N=1 latches ADDR, loads the latency counter with READ_LAT-1 and enters RD_WAIT; with READ_LAT=1, enter RD_DRIVE directly.
- REQ-015: RD_WAIT decrements each cycle and enters RD_DRIVE at 0; in RD_DRIVE, read data is registered from mem[latched ADDR], rd_count increments once on entry, and each lane with UB_N/LB_N=0 is driven while CE_N=0, OE_N=0 and WE_N=1 combinationally; other lanes are high-Z.
- REQ-016: DQ is valid exactly READ_LAT posedges after the read-start edge.
- REQ-017: An ADDR change in RD_WAIT or RD_DRIVE, still reading, restarts the access at the new address with full READ_LAT; rd_count counts only reads reaching RD_DRIVE.
- REQ-018: A sampled WE_N=0 in RD_WAIT/RD_DRIVE aborts the read, releases DQ combinationally in the same cycle, performs the write per REQ-013 and returns to IDLE.
- REQ-019: A sampled CE_N=1 or OE_N=1 in any read state returns to IDLE; DQ is released combinationally.
- REQ-020: A write to the latched address during RD_DRIVE is not reachable per REQ-018; a read-after-write to the same address on the next cycle returns the new data.
- REQ-021: Counter wrap: 16'hFFFF+1 = 16'h0000, no flag.

Reset
- REQ-022: rst forces IDLE, wr_count=0, rd_count=0, proto_err=0, latency counter=0, DQ high-Z; it overrides any in-flight access in the same cycle.
- REQ-023: Memory contents are not reset; a read before any write returns X in simulation.

Configuration
- REQ-024: Macro SRAM_RESP_CHECK_EN: if defined, proto_err pulses for one cycle after any posedge sampling CE_N=0 with WE_N=0 and OE_N=0, or CE_N=0 with UB_N=LB_N=1; the access still proceeds per REQ-013/014.
- REQ-025: If SRAM_RESP_CHECK_EN is undefined, proto_err is tied to 0 and no checker logic is present.

Structure
- REQ-026: Package sram_resp_pkg holds the state enum, SRAM_AW=18, SRAM_DW=16 and the latency-counter width (3).
- REQ-027: Sub-module sram_resp_mem implements the 2^MEM_AW x 16 array with per-lane write enables and registered read; the FSM, counters and checker live in sram_responder.

Verification
- REQ-028: Write 16'hA5C3 to 0x005 (UB_N=LB_N=0), then read 0x005 with READ_LAT=2 -> DQ=16'hA5C3 exactly 2 edges after the sample; wr_count=1, rd_count=1.
- REQ-029: Write 16'h1122 to 0x010, then write 16'hFF00 with UB_N=0 and LB_N=1 -> read returns 16'hFF22.
- REQ-030: Read 0x001 and change ADDR to 0x002 in RD_WAIT -> DQ shows mem[0x002] READ_LAT edges after the change; rd_count increments by 1.
- REQ-031: Assert WE_N=0 during RD_DRIVE -> DQ is high-Z in the same cycle, the write commits and the FSM returns to IDLE.
- REQ-032: With SRAM_RESP_CHECK_EN, drive CE_N=OE_N=WE_N=0 for one cycle -> proto_err=1 for exactly one cycle; without the macro, proto_err stays 0.
- REQ-033: Assert rst during RD_WAIT -> next cycle: IDLE, counters 0, DQ high-Z; previously written memory data is still readable.
